fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter.sv | 89 ++++++++
 tb/tb_fifo_write_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among NUM_REQ producers,
// with each grant bounded to MAX_BURST consecutive writes and no write while the FIFO is full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fifo_full,
  output logic                       fifo_write_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel, cand, gnt_idx;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic found, hit;
  int base;
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction
  // A burst that ends early re-arbitrates from owner+1 and skips the owner in the same cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    hit         = 1'b0;
    gnt_idx     = owner_q;
    found       = 1'b0;
    sel         = '0;
    cand        = '0;
    base        = (state_q == BURST) ? int'(owner_q) + 1 : int'(rr_ptr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((base + k) % NUM_REQ);
      if (!found && req[cand] && !(state_q == BURST && cand == owner_q)) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (!fifo_full && state_q == BURST && req[owner_q]) begin
      hit         = 1'b1;
      burst_cnt_d = burst_cnt_q + 1'b1;
      if (burst_cnt_d == CW'(MAX_BURST)) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
    end else if (!fifo_full) begin
      if (state_q == BURST) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
      if (found) begin
        hit         = 1'b1;
        gnt_idx     = sel;
        owner_d     = sel;
        burst_cnt_d = CW'(1);
        if (MAX_BURST == 1) rr_ptr_d = next_idx(sel);
        else state_d = BURST;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
  assign gnt           = (hit && rst_n) ? NUM_REQ'(1) << gnt_idx : '0;
  assign fifo_write_en = |gnt;
  assign fifo_data_in  = fifo_write_en ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;
  assign owner         = owner_q;
  assign busy          = (state_q == BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed literal sequences plus randomized traffic against a
// queue-style arbitration model and a depth-4 FIFO occupancy model.
module tb_fifo_write_arbiter;
  localparam int N = 4, W = 8, MB = 2, DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n, fifo_full, fifo_write_en, busy;
  logic [N-1:0] req, gnt;
  logic [N*W-1:0] req_data;
  logic [W-1:0] fifo_data_in;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  int hold = -1, run = 0, ptr = 0, m_own = 0, exp_g = -1, m_last = -1, mi;
  int fcnt = 0, dut_wr = 0;
  bit use_fifo = 0, rd = 0;
  logic [N-1:0] exp_v;
  logic [W-1:0] exp_d;

  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !fifo_write_en);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the holder keeps the port while it requests and has fewer than MB writes,
  // otherwise the next requester after the holder (or after ptr) wins.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = -1; run = 0; ptr = 0; m_own = 0;
    end
    exp_g = -1;
    if (rst_n && !fifo_full) begin
      if (hold >= 0 && req[hold] && run < MB) exp_g = hold;
      else for (int k = 0; k < N; k++) begin
        mi = ((hold >= 0 ? hold + 1 : ptr) + k) % N;
        if (exp_g < 0 && req[mi] && mi != hold) exp_g = mi;
      end
    end
    exp_v = (exp_g >= 0) ? N'(1 << exp_g) : '0;
    exp_d = (exp_g >= 0) ? req_data[exp_g*W +: W] : '0;
    chk("m.gnt", gnt, exp_v);
    chk("m.data", fifo_data_in, exp_d);
    chk("m.we", fifo_write_en, exp_g >= 0);
    chk("m.owner", owner, m_own);
    chk("m.busy", busy, hold >= 0);
    chk("m.full_we", fifo_full && fifo_write_en, 0);
    if (rst_n) begin
      if (exp_g >= 0 && exp_g == hold) begin
        run++;
        if (run == MB) begin ptr = (hold + 1) % N; hold = -1; end
      end else if (!fifo_full) begin
        if (hold >= 0) begin ptr = (hold + 1) % N; hold = -1; end
        if (exp_g >= 0) begin
          m_own = exp_g; run = 1;
          if (MB == 1) ptr = (exp_g + 1) % N; else hold = exp_g;
        end
      end
    end
    m_last = exp_g;
    if (use_fifo) begin
      if (rd && fcnt > 0) fcnt--;
      if (exp_g >= 0) fcnt++;
      if (fifo_write_en) dut_wr++;
    end
  end

  task automatic cyc(input logic rn, input logic [3:0] r, input logic [31:0] d, input logic f,
                     input logic [3:0] eg, input logic [7:0] ed, input logic eb,
                     input logic [1:0] eo, input string nm);
    @(posedge clk); #1;
    rst_n = rn; req = r; req_data = d; fifo_full = f;
    #2;
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".data"}, fifo_data_in, ed);
    chk({nm, ".we"}, fifo_write_en, |eg);
    chk({nm, ".busy"}, busy, eb);
    chk({nm, ".owner"}, owner, eo);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; req = '0; fifo_full = 0; rd = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic rnd_cycle();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (m_last == i) begin
        req[i] = ($urandom_range(3) != 0);
        req_data[i*W +: W] = W'($urandom);
      end else if (!req[i]) begin
        if ($urandom_range(2) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end else if ($urandom_range(15) == 0) req[i] = 1'b0;
    end
    rd = ($urandom_range(2) == 0);
    fifo_full = (fcnt == DEPTH);
    rst_n = ($urandom_range(499) != 0);
  endtask

  initial begin
    rst_n = 0; req = 4'hF; req_data = '1; fifo_full = 0;
    cyc(0, 4'hF, 32'hFFFF_FFFF, 0, 4'b0000, 8'h00, 0, 0, "rst");
    // round-robin with wrap 3->0
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0001, 8'h00, 0, 0, "rr1");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0001, 8'h00, 1, 0, "rr2");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0010, 8'h11, 0, 0, "rr3");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0010, 8'h11, 1, 1, "rr4");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0100, 8'h22, 0, 1, "rr5");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0100, 8'h22, 1, 2, "rr6");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b1000, 8'h33, 0, 2, "rr7");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b1000, 8'h33, 1, 3, "rr8");
    cyc(1, 4'hF, 32'h3322_1100, 0, 4'b0001, 8'h00, 0, 3, "rr9");
    // single producer: burst of two, re-arbitration returns to it
    do_reset();
    cyc(1, 4'b0001, 32'h0000_00A1, 0, 4'b0001, 8'hA1, 0, 0, "one1");
    cyc(1, 4'b0001, 32'h0000_00A2, 0, 4'b0001, 8'hA2, 1, 0, "one2");
    cyc(1, 4'b0001, 32'h0000_00A3, 0, 4'b0001, 8'hA3, 0, 0, "one3");
    cyc(1, 4'b0000, 32'h0000_00A3, 0, 4'b0000, 8'h00, 1, 0, "one4");
    cyc(1, 4'b0000, 32'h0000_00A3, 0, 4'b0000, 8'h00, 0, 0, "one5");
    // full stalls a burst, which then resumes and hands over to 2
    do_reset();
    cyc(1, 4'b0010, 32'h0000_5500, 0, 4'b0010, 8'h55, 0, 0, "full1");
    for (int i = 0; i < 3; i++)
      cyc(1, 4'b0010, 32'h0000_5500, 1, 4'b0000, 8'h00, 1, 1, "full_hold");
    cyc(1, 4'b0010, 32'h0000_5500, 0, 4'b0010, 8'h55, 1, 1, "full2");
    cyc(1, 4'b0110, 32'h0066_5500, 0, 4'b0100, 8'h66, 0, 1, "full3");
    // early burst end hands over with no bubble
    do_reset();
    cyc(1, 4'b0100, 32'h0022_0000, 0, 4'b0100, 8'h22, 0, 0, "drop1");
    cyc(1, 4'b1000, 32'h3300_0000, 0, 4'b1000, 8'h33, 1, 2, "drop2");
    cyc(1, 4'b0000, 32'h0000_0000, 0, 4'b0000, 8'h00, 1, 3, "drop3");
    // reset in the middle of a burst
    do_reset();
    cyc(1, 4'b0100, 32'h0022_0000, 0, 4'b0100, 8'h22, 0, 0, "mr1");
    cyc(0, 4'b0101, 32'h0022_0011, 0, 4'b0000, 8'h00, 0, 0, "mr2");
    cyc(1, 4'b0101, 32'h0022_0011, 0, 4'b0001, 8'h11, 0, 0, "mr3");
    // drive a depth-4 FIFO: four writes, then one more per read
    do_reset();
    use_fifo = 1; fcnt = 0; dut_wr = 0; rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req = 4'hF; req_data = 32'h4433_2211; fifo_full = (fcnt == DEPTH);
    end
    chk("fifo.fill", dut_wr, 4);
    @(posedge clk); #1;
    rd = 1; fifo_full = (fcnt == DEPTH);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rd = 0; fifo_full = (fcnt == DEPTH);
    end
    chk("fifo.one_more", dut_wr, 5);
    for (int i = 0; i < 3000; i++) rnd_cycle();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
